// File: rtl/rmt_repair_walker_pkg.sv
// Shared types for the rename-map-table repair walk.
// Used by the RMT, the recovery logic and the repair walker.
package rmt_repair_walker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } rmt_repair_state_t;

    function automatic int rmt_repair_packets(input int depth, input int lanes);
        return (depth + lanes - 1) / lanes;
    endfunction

    localparam int RMT_REPAIR_DEPTH   = 34;
    localparam int RMT_REPAIR_LANES   = 8;
    localparam int RMT_REPAIR_PACKETS =
        rmt_repair_packets(RMT_REPAIR_DEPTH, RMT_REPAIR_LANES);

endpackage

// File: rtl/rmt_repair_walker.sv
// Walks every logical register after recovery, copying AMT
// mappings into the RMT N_PACKETS entries per cycle.
module rmt_repair_walker
    import rmt_repair_walker_pkg::*;
#(
    parameter int DEPTH     = 34,
    parameter int INDEX     = 6,
    parameter int WIDTH     = 7,
    parameter int N_PACKETS = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                repairStart_i,
    output logic [N_PACKETS-1:0][INDEX-1:0]     amtAddr_o,
    input  logic [N_PACKETS-1:0][WIDTH-1:0]     amtData_i,
    output logic                                repairFlag_o,
    output logic [N_PACKETS-1:0][INDEX-1:0]     repairAddr_o,
    output logic [N_PACKETS-1:0][WIDTH-1:0]     repairData_o,
    output logic [N_PACKETS-1:0]                repairValid_o,
    output logic                                busy_o,
    output logic                                done_o
);

    localparam int P  = rmt_repair_packets(DEPTH, N_PACKETS);
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int EW = INDEX + 1;

    rmt_repair_state_t state, state_nxt;
    logic [PW-1:0]     pkt, pkt_nxt;
    logic              walk;
    logic [EW-1:0]     base;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pkt   <= '0;
        end else begin
            state <= state_nxt;
            pkt   <= pkt_nxt;
        end
    end

    // A start request always wins: it (re)opens the walk at packet 0.
    always_comb begin
        state_nxt = state;
        pkt_nxt   = pkt;
        unique case (state)
            IDLE: begin
                if (repairStart_i) begin
                    state_nxt = WALK;
                    pkt_nxt   = '0;
                end
            end
            WALK: begin
                if (repairStart_i) begin
                    pkt_nxt = '0;
                end else if (pkt == PW'(P - 1)) begin
                    state_nxt = DONE;
                end else begin
                    pkt_nxt = pkt + PW'(1);
                end
            end
            DONE: begin
                pkt_nxt   = '0;
                state_nxt = repairStart_i ? WALK : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                pkt_nxt   = '0;
            end
        endcase
    end

    assign walk         = (state == WALK);
    assign repairFlag_o = walk;
    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE);

    // One bit wider than INDEX so the last packet cannot wrap past DEPTH.
    assign base = EW'(pkt) * EW'(N_PACKETS);

    for (genvar i = 0; i < N_PACKETS; i++) begin : g_lane
        logic [EW-1:0] e;
        logic          live;

        assign e    = base + EW'(i);
        assign live = walk && (e < EW'(DEPTH));

        assign amtAddr_o[i]     = live ? e[INDEX-1:0] : '0;
        assign repairAddr_o[i]  = live ? e[INDEX-1:0] : '0;
        assign repairData_o[i]  = live ? amtData_i[i] : '0;
        assign repairValid_o[i] = live;
    end

endmodule

// File: tb/tb_rmt_repair_walker.sv
// Directed scoreboard bench: DEPTH=34 and DEPTH=32 walkers
// share clock, reset and start; AMT entry k holds tag k+40.
module tb_rmt_repair_walker;

    localparam int N  = 8;
    localparam int IW = 6;
    localparam int TW = 7;

    // Scoreboard codes: >=0 packet index, -1 idle, -2 done.
    localparam int C_IDLE = -1;
    localparam int C_DONE = -2;

    typedef struct {
        int a;
        int b;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic start;

    logic [N-1:0][IW-1:0] a_amt_addr, a_raddr, b_amt_addr, b_raddr;
    logic [N-1:0][TW-1:0] a_amt_data, a_rdata, b_amt_data, b_rdata;
    logic [N-1:0]         a_valid, b_valid;
    logic                 a_flag, a_busy, a_done;
    logic                 b_flag, b_busy, b_done;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_amt
        assign a_amt_data[i] = TW'(a_amt_addr[i] + 40);
        assign b_amt_data[i] = TW'(b_amt_addr[i] + 40);
    end

    rmt_repair_walker #(
        .DEPTH(34), .INDEX(IW), .WIDTH(TW), .N_PACKETS(N)
    ) dut_a (
        .clk(clk), .reset(reset), .repairStart_i(start),
        .amtAddr_o(a_amt_addr), .amtData_i(a_amt_data),
        .repairFlag_o(a_flag), .repairAddr_o(a_raddr),
        .repairData_o(a_rdata), .repairValid_o(a_valid),
        .busy_o(a_busy), .done_o(a_done)
    );

    rmt_repair_walker #(
        .DEPTH(32), .INDEX(IW), .WIDTH(TW), .N_PACKETS(N)
    ) dut_b (
        .clk(clk), .reset(reset), .repairStart_i(start),
        .amtAddr_o(b_amt_addr), .amtData_i(b_amt_data),
        .repairFlag_o(b_flag), .repairAddr_o(b_raddr),
        .repairData_o(b_rdata), .repairValid_o(b_valid),
        .busy_o(b_busy), .done_o(b_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cmp(input string who, input int depth, input int code,
                       input logic flag, input logic busy, input logic done,
                       input logic [N-1:0][IW-1:0] amt,
                       input logic [N-1:0][IW-1:0] raddr,
                       input logic [N-1:0][TW-1:0] rdata,
                       input logic [N-1:0] valid);
        logic [N-1:0][IW-1:0] ea;
        logic [N-1:0][TW-1:0] ed;
        logic [N-1:0]         ev;
        ea = '0;
        ed = '0;
        ev = '0;
        if (code >= 0) begin
            for (int i = 0; i < N; i++) begin
                int e;
                e = code * N + i;
                if (e < depth) begin
                    ev[i] = 1'b1;
                    ea[i] = IW'(e);
                    ed[i] = TW'(e + 40);
                end
            end
        end
        chk({who, "_flag"}, 64'(flag), 64'(code >= 0));
        chk({who, "_busy"}, 64'(busy), 64'(code != C_IDLE));
        chk({who, "_done"}, 64'(done), 64'(code == C_DONE));
        chk({who, "_amt_addr"}, 64'(amt), 64'(ea));
        chk({who, "_rep_addr"}, 64'(raddr), 64'(ea));
        chk({who, "_rep_data"}, 64'(rdata), 64'(ed));
        chk({who, "_rep_valid"}, 64'(valid), 64'(ev));
    endtask

    task automatic check_now(input int ca, input int cb);
        cmp("a", 34, ca, a_flag, a_busy, a_done,
            a_amt_addr, a_raddr, a_rdata, a_valid);
        cmp("b", 32, cb, b_flag, b_busy, b_done,
            b_amt_addr, b_raddr, b_rdata, b_valid);
    endtask

    task automatic push(input int ca, input int cb);
        exp_t x;
        x.a = ca;
        x.b = cb;
        sb.push_back(x);
    endtask

    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        n_total++;
        assert (sb.size() > 0) n_pass++;
        else $error("FAIL sb_empty observed=%0d expected=%0d", 0, 1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check_now(x.a, x.b);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        #1;
        check_now(C_IDLE, C_IDLE);

        // Reset then idle.
        push(C_IDLE, C_IDLE);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 10; k++) push(C_IDLE, C_IDLE);
        for (int k = 0; k < 10; k++) tick();

        // Full walk: A 5 packets + done at T+6, B 4 packets + done at T+5.
        for (int p = 0; p < 5; p++) push(p, (p < 4) ? p : C_DONE);
        push(C_DONE, C_IDLE);
        push(C_IDLE, C_IDLE);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        tick();
        chk("a_last_valid", 64'(a_valid), 64'h03);
        tick();
        tick();

        // Restart at T+3: packet 0 again at T+4, done only at T+9 (A).
        push(0, 0);
        push(1, 1);
        push(2, 2);
        for (int p = 0; p < 5; p++) push(p, (p < 4) ? p : C_DONE);
        push(C_DONE, C_IDLE);
        push(C_IDLE, C_IDLE);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        // Reset asserted at T+2 abandons the walk.
        push(0, 0);
        push(1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check_now(C_IDLE, C_IDLE);
        push(C_IDLE, C_IDLE);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) push(C_IDLE, C_IDLE);
        for (int k = 0; k < 4; k++) tick();

        // Start during A's DONE cycle: straight back into packet 0.
        for (int p = 0; p < 5; p++) push(p, (p < 4) ? p : C_DONE);
        push(C_DONE, C_IDLE);
        for (int p = 0; p < 5; p++) push(p, (p < 4) ? p : C_DONE);
        push(C_DONE, C_IDLE);
        push(C_IDLE, C_IDLE);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
